// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, H/V counters, sync generation
// and a one-pixel-delayed output register selecting external pixels or colour bars.
module vga_timing_gen #(
   parameter int H_ACTIVE     = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FP         = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 33,
   parameter int CLK_DIV      = 4,
   parameter int COLOR_W      = 4,
   parameter int SYNC_ACT_LOW = 1,
   localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int XW          = $clog2(H_TOTAL),
   localparam int YW          = $clog2(V_TOTAL)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mode,
   input  logic [3*COLOR_W-1:0]   pixel_in,
   output logic [XW-1:0]          pixel_x,
   output logic [YW-1:0]          pixel_y,
   output logic                   de_req,
   output logic                   pix_en,
   output logic                   frame_start,
   output logic [COLOR_W-1:0]     VGA_RED,
   output logic [COLOR_W-1:0]     VGA_GREEN,
   output logic [COLOR_W-1:0]     VGA_BLUE,
   output logic                   VGA_HSYNC,
   output logic                   VGA_VSYNC
);

   if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_check
      $error("vga_timing_gen: CLK_DIV and all timing parameters must be >= 1");
   end

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
   localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
   localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
   localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic SYNC_ON = (SYNC_ACT_LOW != 0) ? 1'b0 : 1'b1;

   logic [DIV_W-1:0]   div_q, div_d;
   logic [XW-1:0]      x_q, x_d;
   logic [YW-1:0]      y_q, y_d;
   logic               hs_q, hs_d, vs_q, vs_d;
   logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic               active;
   logic [2:0]         bar;

   assign pix_en      = (div_q == DIV_LAST);
   assign active      = (x_q < X_ACT) && (y_q < Y_ACT);
   assign de_req      = active;
   assign frame_start = reset && pix_en && (x_q == '0) && (y_q == '0);

   assign pixel_x   = x_q;
   assign pixel_y   = y_q;
   assign VGA_RED   = r_q;
   assign VGA_GREEN = g_q;
   assign VGA_BLUE  = b_q;
   assign VGA_HSYNC = hs_q;
   assign VGA_VSYNC = vs_q;

   always_comb begin
      div_d = pix_en ? '0 : div_q + 1'b1;
      x_d   = x_q;
      y_d   = y_q;
      if (pix_en) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // bar = floor(x*8/H_ACTIVE) found by threshold compares, avoiding a divider
   always_comb begin
      bar = '0;
      for (int unsigned k = 1; k < 8; k++) begin
         if ({x_q, 3'b000} >= (XW+3)'(k * H_ACTIVE)) bar = 3'(k);
      end
   end

   always_comb begin
      hs_d = hs_q;
      vs_d = vs_q;
      r_d  = r_q;
      g_d  = g_q;
      b_d  = b_q;
      if (pix_en) begin
         hs_d = (x_q >= HS_START && x_q < HS_END) ? SYNC_ON : ~SYNC_ON;
         vs_d = (y_q >= VS_START && y_q < VS_END) ? SYNC_ON : ~SYNC_ON;
         if (!active) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
         end else if (mode) begin
            r_d = {COLOR_W{~bar[1]}};
            g_d = {COLOR_W{~bar[2]}};
            b_d = {COLOR_W{~bar[0]}};
         end else begin
            {r_d, g_d, b_d} = pixel_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         div_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
         hs_q  <= ~SYNC_ON;
         vs_q  <= ~SYNC_ON;
         r_q   <= '0;
         g_q   <= '0;
         b_q   <= '0;
      end else begin
         div_q <= div_d;
         x_q   <= x_d;
         y_q   <= y_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         r_q   <= r_d;
         g_q   <= g_d;
         b_q   <= b_d;
      end
   end

endmodule
